// File: rtl/serial_input_block_pkg.sv
// Shared defaults and mode encoding for the serial frame buffer.
`timescale 1ns/1ps
package serial_input_block_pkg;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

   typedef enum logic {
      MODE_FILL  = 1'b0,
      MODE_DRAIN = 1'b1
   } mode_t;
endpackage

// File: rtl/serial_input_block_bit_buffer.sv
// DEPTH x 1 single-port bit store: one-hot word select over a flop array.
`timescale 1ns/1ps
module bit_buffer #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic              din,
   output logic              dout
);
   logic [DEPTH-1:0] r_mem;
   logic [DEPTH-1:0] w_sel;
   logic             w_rd;

   always_comb begin
      w_sel       = '0;
      w_sel[addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (we && w_sel[i]) r_mem[i] <= din;
      end
   end

   // Read data is captured by the caller's output register on the same edge.
   always_comb begin
      w_rd = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_rd = w_rd | (w_sel[i] & r_mem[i]);
      end
   end

   assign dout = w_rd;
endmodule

// File: rtl/serial_input_block.sv
// Captures a DEPTH-bit serial frame, then replays it with a valid strobe
// and a per-frame running XOR integral; FILL and DRAIN alternate forever.
`timescale 1ns/1ps
module serial_input_block
   import serial_input_block_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic clk,
   input  logic reset,
   input  logic bin_in,
   output logic bin_out,
   output logic bin_int_out,
   output logic valid,
   output logic mode
);
   mode_t             r_mode;
   mode_t             w_mode_nxt;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_ptr_nxt;
   logic              w_last;
   logic              w_we;
   logic              w_rd;
   logic              r_out;
   logic              r_int;
   logic              r_valid;

   assign w_last = (r_ptr == ADDR_W'(DEPTH - 1));
   assign w_we   = (r_mode == MODE_FILL);

   bit_buffer #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_buf (
      .clk (clk),
      .we  (w_we),
      .addr(r_ptr),
      .din (bin_in),
      .dout(w_rd)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode <= MODE_FILL;
         r_ptr  <= '0;
      end else begin
         r_mode <= w_mode_nxt;
         r_ptr  <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_mode_nxt = r_mode;
      w_ptr_nxt  = r_ptr + ADDR_W'(1);
      if (w_last) begin
         w_ptr_nxt  = '0;
         w_mode_nxt = (r_mode == MODE_FILL) ? MODE_DRAIN : MODE_FILL;
      end
   end

   // Integral restarts with the first bit of every replayed frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out   <= 1'b0;
         r_int   <= 1'b0;
         r_valid <= 1'b0;
      end else if (r_mode == MODE_DRAIN) begin
         r_out   <= w_rd;
         r_int   <= (r_ptr == '0) ? w_rd : (r_int ^ w_rd);
         r_valid <= 1'b1;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign bin_out     = r_out;
   assign bin_int_out = r_int;
   assign valid       = r_valid;
   assign mode        = r_mode;
endmodule

// File: tb/tb_serial_input_block.sv
// Randomized bench for serial_input_block with a frame-level reference model.
`timescale 1ns/1ps
module tb_serial_input_block;
   localparam int D = 64;

   logic clk    = 1'b0;
   logic clk_en = 1'b0;
   logic reset  = 1'b0;
   logic bin_in = 1'b0;
   logic bin_out, bin_int_out, valid, mode;

   int n_checks = 0;
   int n_fail   = 0;

   int m_n;
   bit m_frame[D];
   bit e_out, e_int, e_valid, e_mode;

   serial_input_block dut (
      .clk        (clk),
      .reset      (reset),
      .bin_in     (bin_in),
      .bin_out    (bin_out),
      .bin_int_out(bin_int_out),
      .valid      (valid),
      .mode       (mode)
   );

   always #1 clk = clk_en ? ~clk : 1'b0;

   task automatic model_reset();
      m_n = 0;
      e_out = 0; e_int = 0; e_valid = 0; e_mode = 0;
   endtask

   // Edges since reset: phase < D captures, phase >= D replays bit (phase-D).
   task automatic model_edge(input bit b);
      int p, i;
      bit acc;
      p = m_n % (2 * D);
      if (p < D) begin
         m_frame[p] = b;
         e_valid = 0;
      end else begin
         i = p - D;
         acc = 0;
         for (int k = 0; k <= i; k++) acc ^= m_frame[k];
         e_out = m_frame[i];
         e_int = acc;
         e_valid = 1;
      end
      m_n++;
      e_mode = ((m_n / D) % 2) == 1;
   endtask

   task automatic drive_edge(input bit b);
      bin_in = b;
      @(posedge clk);
      model_edge(b);
      @(negedge clk);
   endtask

   task automatic test_reset();
      clk_en = 1'b0;
      #1 reset = 1'b1;
      #2;
      n_checks++;
      if ({mode, valid, bin_out, bin_int_out} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_no_clk: got %b expected 0000",
                  {mode, valid, bin_out, bin_int_out});
      end
      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      n_checks++;
      if ({mode, valid, bin_out, bin_int_out} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_release: got %b expected 0000",
                  {mode, valid, bin_out, bin_int_out});
      end
   endtask

   task automatic test_toggle();
      for (int i = 0; i < D; i++) begin
         drive_edge(1'(i % 2));
         n_checks++;
         if ({mode, valid} !== {e_mode, e_valid}) begin
            n_fail++;
            $display("FAIL toggle_fill[%0d]: mode/valid %b expected %b",
                     i, {mode, valid}, {e_mode, e_valid});
         end
      end
      for (int i = 0; i < D; i++) begin
         drive_edge(1'(i % 2));
         n_checks++;
         if ({mode, valid, bin_out, bin_int_out} !==
             {e_mode, e_valid, 1'(i % 2), 1'(((i + 1) >> 1) & 1)}) begin
            n_fail++;
            $display("FAIL toggle_drain[%0d]: got %b expected %b", i,
                     {mode, valid, bin_out, bin_int_out},
                     {e_mode, e_valid, 1'(i % 2), 1'(((i + 1) >> 1) & 1)});
         end
      end
   endtask

   task automatic test_const_ones();
      for (int i = 0; i < D; i++) drive_edge(1'b1);
      n_checks++;
      if (mode !== 1'b1 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ones_fill_end: mode %b valid %b expected 1 0",
                  mode, valid);
      end
      for (int i = 0; i < D; i++) begin
         drive_edge(1'b1);
         n_checks++;
         if ({valid, bin_out, bin_int_out} !==
             {1'b1, 1'b1, 1'(i % 2 == 0)}) begin
            n_fail++;
            $display("FAIL ones_drain[%0d]: got %b expected %b", i,
                     {valid, bin_out, bin_int_out},
                     {1'b1, 1'b1, 1'(i % 2 == 0)});
         end
      end
      drive_edge(1'b0);
      n_checks++;
      if ({mode, valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL ones_valid_drop: mode/valid %b expected 00",
                  {mode, valid});
      end
   endtask

   task automatic test_multi_frame();
      int n_cyc, n_valid, n_tog;
      logic prev_mode;
      n_cyc = 156 * 2 * D;
      n_valid = 0;
      n_tog = 0;
      prev_mode = mode;
      for (int i = 0; i < n_cyc; i++) begin
         drive_edge(1'($urandom));
         if (valid === 1'b1) n_valid++;
         if (mode !== prev_mode) n_tog++;
         prev_mode = mode;
         n_checks++;
         if ({mode, valid, bin_out, bin_int_out} !==
             {e_mode, e_valid, e_out, e_int}) begin
            n_fail++;
            $display("FAIL multi[%0d]: got %b expected %b", i,
                     {mode, valid, bin_out, bin_int_out},
                     {e_mode, e_valid, e_out, e_int});
         end
      end
      n_checks++;
      if (n_valid != n_cyc / 2) begin
         n_fail++;
         $display("FAIL multi_duty: valid cycles %0d expected %0d",
                  n_valid, n_cyc / 2);
      end
      n_checks++;
      if (n_tog != n_cyc / D) begin
         n_fail++;
         $display("FAIL multi_toggles: mode toggles %0d expected %0d",
                  n_tog, n_cyc / D);
      end
   endtask

   task automatic test_reset_mid_drain();
      int guard;
      guard = 0;
      while (m_n % (2 * D) != D + D / 2 && guard < 2 * D + 1) begin
         drive_edge(1'($urandom));
         guard++;
      end
      n_checks++;
      if ({mode, valid} !== 2'b11 || m_n % (2 * D) != D + D / 2) begin
         n_fail++;
         $display("FAIL mid_align: mode/valid %b expected 11 (guard %0d)",
                  {mode, valid}, guard);
      end
      reset = 1'b1;
      #0.3;
      n_checks++;
      if ({mode, valid, bin_out, bin_int_out} !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_async: got %b expected 0000",
                  {mode, valid, bin_out, bin_int_out});
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 2 * D; i++) begin
         drive_edge(1'($urandom));
         n_checks++;
         if ({mode, valid, bin_out, bin_int_out} !==
             {e_mode, e_valid, e_out, e_int}) begin
            n_fail++;
            $display("FAIL mid_after[%0d]: got %b expected %b", i,
                     {mode, valid, bin_out, bin_int_out},
                     {e_mode, e_valid, e_out, e_int});
         end
      end
   endtask

   task automatic test_drain_random();
      bit cap[D];
      bit acc;
      for (int i = 0; i < D; i++) begin
         cap[i] = 1'($urandom);
         drive_edge(cap[i]);
      end
      acc = 0;
      for (int i = 0; i < D; i++) begin
         drive_edge(1'($urandom));
         acc ^= cap[i];
         n_checks++;
         if ({valid, bin_out, bin_int_out} !== {1'b1, cap[i], acc} ||
             {mode, bin_out} !== {e_mode, e_out}) begin
            n_fail++;
            $display("FAIL drain_rand[%0d]: got %b expected %b", i,
                     {mode, valid, bin_out, bin_int_out},
                     {e_mode, 1'b1, cap[i], acc});
         end
      end
   endtask

   initial begin
      test_reset();
      test_toggle();
      test_const_ones();
      test_multi_frame();
      test_reset_mid_drain();
      test_drain_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
